// File: rtl/gck_pkg.sv
// Shared types and defaults for the clock-gating sequencer.
package gck_pkg;

  typedef enum logic [1:0] {
    GCK_OFF   = 2'd0,
    GCK_WAKE  = 2'd1,
    GCK_ON    = 2'd2,
    GCK_DRAIN = 2'd3
  } gck_state_e;

  localparam int GCK_WAKE_CYC_DEF = 2;
  localparam int GCK_IDLE_W_DEF   = 8;

endpackage

// File: rtl/gck_ctrl_chan.sv
// One clock domain: idle hysteresis, one-cycle drain notice, gated-off and
// wake-settle phases. gate_en/clk_ack are registered from the next state.
module gck_ctrl_chan
  import gck_pkg::*;
#(
  parameter int IDLE_W   = GCK_IDLE_W_DEF,
  parameter int WAKE_CYC = GCK_WAKE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keep_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  output logic              gate_en_o,
  output logic              clk_ack_o,
  output gck_state_e        state_o
);

  localparam int WCNT_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYC - 1);

  gck_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              gate_en_q, gate_en_d;
  logic              clk_ack_q, clk_ack_d;
  logic [IDLE_W:0]   idle_inc;

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    wcnt_d   = wcnt_q;
    idle_inc = {1'b0, idle_q} + 1'b1;
    unique case (state_q)
      GCK_ON: begin
        if (keep_i || (idle_thr_i == '0)) begin
          idle_d = '0;
        end else if (idle_inc >= {1'b0, idle_thr_i}) begin
          // Live compare: a lowered threshold drains on the next idle cycle.
          state_d = GCK_DRAIN;
          idle_d  = '0;
        end else begin
          idle_d = idle_inc[IDLE_W] ? '1 : idle_inc[IDLE_W-1:0];
        end
      end
      GCK_DRAIN: begin
        state_d = keep_i ? GCK_ON : GCK_OFF;
        idle_d  = '0;
      end
      GCK_OFF: begin
        if (keep_i) begin
          state_d = GCK_WAKE;
          wcnt_d  = '0;
        end
      end
      GCK_WAKE: begin
        // Settle always runs to completion regardless of inputs.
        if (wcnt_q == WAKE_LAST) begin
          state_d = GCK_ON;
          idle_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = GCK_ON;
    endcase
    gate_en_d = (state_d != GCK_OFF);
    clk_ack_d = (state_d == GCK_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GCK_ON;
      idle_q    <= '0;
      wcnt_q    <= '0;
      gate_en_q <= 1'b1;
      clk_ack_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      wcnt_q    <= wcnt_d;
      gate_en_q <= gate_en_d;
      clk_ack_q <= clk_ack_d;
    end
  end

  assign gate_en_o = gate_en_q;
  assign clk_ack_o = clk_ack_q;
  assign state_o   = state_q;

endmodule

// File: rtl/gck_ctrl.sv
// Per-domain ICG enable sequencer: one channel per domain plus the shared,
// one-cycle-delayed test enable.
module gck_ctrl
  import gck_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = GCK_IDLE_W_DEF,
  parameter int WAKE_CYC = GCK_WAKE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDLE_W-1:0]  cfg_idle_thr,
  input  logic               cfg_gate_dis,
  input  logic [N_DOM-1:0]   cfg_force_on,
  input  logic               test_mode,
  input  logic [N_DOM-1:0]   busy,
  input  logic [N_DOM-1:0]   wake_req,
  output logic [N_DOM-1:0]   gate_en,
  output logic               gate_te,
  output logic [N_DOM-1:0]   clk_ack,
  output logic [2*N_DOM-1:0] dom_state
);

  logic gate_te_q;

  always_ff @(posedge clk) begin
    if (rst) gate_te_q <= 1'b0;
    else     gate_te_q <= test_mode;
  end

  assign gate_te = gate_te_q;

  for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
    gck_state_e st;
    logic       keep;

    assign keep = busy[gi] | wake_req[gi] | cfg_force_on[gi] | cfg_gate_dis;

    gck_ctrl_chan #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .keep_i     (keep),
      .idle_thr_i (cfg_idle_thr),
      .gate_en_o  (gate_en[gi]),
      .clk_ack_o  (clk_ack[gi]),
      .state_o    (st)
    );

    assign dom_state[2*gi +: 2] = st;
  end

endmodule

// File: tb/tb_gck_ctrl.sv
// Bench for gck_ctrl: vector table, directed corner sequences, random run,
// all cross-checked every cycle against a behavioural domain model.
`timescale 1ns/1ps
module tb_gck_ctrl;

  localparam int N   = 4;
  localparam int WC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thr;
  logic       dis;
  logic [3:0] force_v;
  logic       tm;
  logic [3:0] busy;
  logic [3:0] wake;
  logic [3:0] gate_en;
  logic       gate_te;
  logic [3:0] clk_ack;
  logic [7:0] dom_state;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 OFF, 1 WAKE, 2 ON, 3 DRAIN
  int m_st[N];
  int m_idle[N];
  int m_wleft[N];
  bit m_te;

  always #5 clk = ~clk;

  gck_ctrl #(.N_DOM(N), .IDLE_W(8), .WAKE_CYC(WC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_idle_thr (thr),
    .cfg_gate_dis (dis),
    .cfg_force_on (force_v),
    .test_mode    (tm),
    .busy         (busy),
    .wake_req     (wake),
    .gate_en      (gate_en),
    .gate_te      (gate_te),
    .clk_ack      (clk_ack),
    .dom_state    (dom_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit keep;
      keep = busy[i] | wake[i] | force_v[i] | dis;
      if (rst) begin
        m_st[i] = 2; m_idle[i] = 0;
      end else begin
        case (m_st[i])
          2: if (keep || thr == 0) m_idle[i] = 0;
             else begin
               m_idle[i]++;
               if (m_idle[i] >= thr) begin m_st[i] = 3; m_idle[i] = 0; end
             end
          3: m_st[i] = keep ? 2 : 0;
          0: if (keep) begin m_st[i] = 1; m_wleft[i] = WC; end
          default: begin
            m_wleft[i]--;
            if (m_wleft[i] == 0) begin m_st[i] = 2; m_idle[i] = 0; end
          end
        endcase
      end
    end
    m_te = rst ? 1'b0 : tm;
  endtask

  function automatic logic [3:0] m_gate();
    for (int i = 0; i < N; i++) m_gate[i] = (m_st[i] != 0);
  endfunction
  function automatic logic [3:0] m_ack();
    for (int i = 0; i < N; i++) m_ack[i] = (m_st[i] == 2);
  endfunction
  function automatic logic [7:0] m_state();
    for (int i = 0; i < N; i++) m_state[2*i +: 2] = 2'(m_st[i]);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gate_en", gate_en, m_gate());
    chk("clk_ack", clk_ack, m_ack());
    chk("gate_te", gate_te, m_te);
    chk("dom_state", dom_state, m_state());
  endtask

  task automatic do_reset(input logic [7:0] t);
    rst = 1; busy = 0; wake = 0; force_v = 0; dis = 0; tm = 0; thr = t;
    step(); step();
    rst = 0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] busy, wake, fon;
    logic       dis, tm;
    logic [7:0] thr;
    logic [3:0] e_gate, e_ack;
    logic       e_te;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic g2_ok;
    vt[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2, 4'hF, 4'hF, 1'b0};
    vt[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2, 4'hF, 4'hF, 1'b0};
    vt[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2, 4'hF, 4'h0, 1'b0};
    vt[3]  = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2, 4'h1, 4'h1, 1'b0};
    vt[4]  = '{1'b0, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 8'd2, 4'h3, 4'h1, 1'b0};
    vt[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2, 4'h3, 4'h0, 1'b0};
    vt[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2, 4'h2, 4'h2, 1'b0};
    vt[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd2, 4'h2, 4'h2, 1'b1};
    vt[8]  = '{1'b0, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 8'd2, 4'hA, 4'h0, 1'b0};
    vt[9]  = '{1'b0, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 8'd2, 4'h8, 4'h0, 1'b0};
    vt[10] = '{1'b0, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 8'd2, 4'h8, 4'h8, 1'b0};
    vt[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0, 4'h8, 4'h8, 1'b0};

    for (int i = 0; i < N; i++) begin m_st[i] = 2; m_idle[i] = 0; m_wleft[i] = 0; end
    m_te = 0;

    // Vector table
    for (int v = 0; v < 12; v++) begin
      rst = vt[v].rst; busy = vt[v].busy; wake = vt[v].wake; force_v = vt[v].fon;
      dis = vt[v].dis; tm = vt[v].tm; thr = vt[v].thr;
      step();
      chk($sformatf("vec%0d_gate", v), gate_en, vt[v].e_gate);
      chk($sformatf("vec%0d_ack", v), clk_ack, vt[v].e_ack);
      chk($sformatf("vec%0d_te", v), gate_te, vt[v].e_te);
    end

    // Reset defaults and idle-to-off latency, thr=4
    do_reset(8'd4);
    chk("rst_gate", gate_en, 4'hF);
    chk("rst_ack", clk_ack, 4'hF);
    chk("rst_te", gate_te, 1'b0);
    step(); step(); step();
    chk("idle3_on", dom_state[1:0], 2'd2);
    step();
    chk("idle4_drain", dom_state[1:0], 2'd3);
    chk("idle4_gate", gate_en[0], 1'b1);
    step();
    chk("idle5_gate", gate_en[0], 1'b0);

    // Wake latency on domain 1
    step();
    wake = 4'b0010; step(); wake = 0;
    chk("wake_t1_gate", gate_en[1], 1'b1);
    chk("wake_t1_ack", clk_ack[1], 1'b0);
    step();
    chk("wake_t2_ack", clk_ack[1], 1'b0);
    step();
    chk("wake_t3_ack", clk_ack[1], 1'b1);
    chk("wake_t3_state", dom_state[3:2], 2'd2);

    // Hysteresis rescue on domain 2
    do_reset(8'd4);
    g2_ok = 1'b1;
    step(); step(); step();
    busy = 4'b0100; step(); busy = 0;
    chk("rescue_state", dom_state[5:4], 2'd2);
    step(); step(); step();
    chk("rescue_cleared", dom_state[5:4], 2'd2);
    step();
    chk("rescue_drain", dom_state[5:4], 2'd3);
    busy = 4'b0100; step(); busy = 0;
    chk("drain_back_on", dom_state[5:4], 2'd2);
    chk("drain_gate_kept", gate_en[2], 1'b1);

    // Force-on with thr=1
    do_reset(8'd1);
    force_v = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      step();
      if (dom_state[7:6] != 2'd2) g2_ok = 1'b0;
    end
    chk("force_on_held", g2_ok, 1'b1);
    force_v = 0;

    // Global disable from all-off
    do_reset(8'd1);
    step(); step();
    chk("all_off", gate_en, 4'h0);
    dis = 1; step();
    chk("dis_wake", dom_state, 8'h55);
    step();
    chk("dis_ack_early", clk_ack, 4'h0);
    step();
    chk("dis_ack", clk_ack, 4'hF);
    dis = 0;

    // thr=0 never gates
    do_reset(8'd0);
    for (int c = 0; c < 20; c++) step();
    chk("thr0_gate", gate_en, 4'hF);

    // Threshold lowered below live count
    do_reset(8'd200);
    for (int c = 0; c < 50; c++) step();
    chk("thr200_on", dom_state, 8'hAA);
    thr = 8'd3; step();
    chk("thr_lower_drain", dom_state, 8'hFF);

    // Reset during WAKE
    do_reset(8'd1);
    step(); step();
    wake = 4'hF; step(); wake = 0;
    chk("pre_rst_wake", dom_state, 8'h55);
    rst = 1; step(); rst = 0;
    chk("rst_wake_ack", clk_ack, 4'hF);
    chk("rst_wake_gate", gate_en, 4'hF);

    // Test mode with FSMs still gating
    do_reset(8'd1);
    tm = 1; step();
    chk("te_on", gate_te, 1'b1);
    step();
    chk("te_gating", gate_en, 4'h0);
    tm = 0; step();
    chk("te_off", gate_te, 1'b0);

    // Random run against the model
    do_reset(8'd3);
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      busy    = 4'($urandom & $urandom);
      wake    = 4'($urandom & $urandom & $urandom);
      force_v = 4'($urandom & $urandom & $urandom & $urandom);
      dis     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) tm = ~tm;
      if ($urandom_range(0, 63) == 0) thr = 8'($urandom_range(0, 6));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
